// File: rtl/seq_multdiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// Fixed latency: start edge at cycle 0, one-cycle RDY strobe in cycle WIDTH+1.
module seq_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   hi;     // Booth high half (one guard bit) / divide remainder
  logic [WIDTH-1:0] lo;     // multiplier / dividend shifting out, quotient shifting in
  logic             qm1;
  logic [WIDTH-1:0] op;     // multiplicand or divisor magnitude
  logic             neg, dz, dov;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;

  logic             last;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mext, bsum, mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic             mul_ovf;
  logic [WIDTH:0]   sh, div_rem_n;
  logic             ge;
  logic [WIDTH-1:0] div_quo_n, div_res;

  assign last  = (cnt == CW'(WIDTH-1));
  assign abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (ctrl_MULT)     state_n = MUL;
            else if (ctrl_DIV) state_n = DIV;
      MUL:  if (last) state_n = DONE;
      DIV:  if (last) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Booth step followed by arithmetic right shift of {hi, lo, qm1}
  always_comb begin
    mext = {op[WIDTH-1], op};
    case ({lo[0], qm1})
      2'b01:   bsum = hi + mext;
      2'b10:   bsum = hi - mext;
      default: bsum = hi;
    endcase
    mul_hi_n = {bsum[WIDTH], bsum[WIDTH:1]};
    mul_lo_n = {bsum[0], lo[WIDTH-1:1]};
    mul_ovf  = (mul_hi_n != {(WIDTH+1){mul_lo_n[WIDTH-1]}});
  end

  // Restoring divide step; remainder always stays below the divisor
  always_comb begin
    sh        = {hi[WIDTH-1:0], lo[WIDTH-1]};
    ge        = (sh >= {1'b0, op});
    div_rem_n = ge ? (sh - {1'b0, op}) : sh;
    div_quo_n = {lo[WIDTH-2:0], ge};
    div_res   = dz ? '0 : (neg ? (~div_quo_n + WIDTH'(1)) : div_quo_n);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0; hi <= '0; lo <= '0; qm1 <= 1'b0; op <= '0;
      neg <= 1'b0; dz <= 1'b0; dov <= 1'b0;
      result_q <= '0; exc_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_MULT) begin
            op <= data_operandA; lo <= data_operandB; hi <= '0; qm1 <= 1'b0;
            cnt <= '0; neg <= 1'b0; dz <= 1'b0; dov <= 1'b0;
          end else if (ctrl_DIV) begin
            op <= abs_b; lo <= abs_a; hi <= '0; qm1 <= 1'b0; cnt <= '0;
            neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz  <= (data_operandB == '0);
            dov <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
          end
        end
        MUL: begin
          hi <= mul_hi_n; lo <= mul_lo_n; qm1 <= lo[0]; cnt <= cnt + CW'(1);
          if (last) begin
            result_q <= mul_lo_n;
            exc_q    <= mul_ovf;
          end
        end
        DIV: begin
          hi <= div_rem_n; lo <= div_quo_n; cnt <= cnt + CW'(1);
          if (last) begin
            result_q <= div_res;
            exc_q    <= dz | dov;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state == DONE);
  assign busy           = (state != IDLE);
endmodule
